// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter: one byte at a time, tx_send pulse,
// then wait for a rising tx_finish before handing over the next byte.
module uart_tx_feeder #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_send,
  input  logic              tx_finish,
  output logic              busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT
  } state_e;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              fin_q, fin_rise;
  logic              tx_send_q, tx_send_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  state_e            state_q, state_d;
  logic              push, pop;
  logic              full_w, empty_w;

  assign full_w   = (count_q == CNT_W'(DEPTH));
  assign empty_w  = (count_q == '0);
  assign fin_rise = tx_finish & ~fin_q;

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty_w) begin
          pop       = 1'b1;
          tx_data_d = mem_q[rd_ptr_q];
          state_d   = ST_SEND;
        end
      end
      ST_SEND: state_d = ST_WAIT;
      ST_WAIT: begin
        // Only edges seen here complete a byte; a rise during SEND is ignored.
        if (fin_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    tx_send_d = (state_d == ST_SEND);
  end

  always_comb begin
    // full is taken from the registered count, so a pop this cycle cannot
    // make room for a simultaneous write.
    push     = wr_en & ~full_w;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    ovf_d    = ovf_q;
    if (clr_ovf)          ovf_d = 1'b0;
    if (wr_en && full_w)  ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      fin_q     <= 1'b0;
      tx_send_q <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      fin_q     <= tx_finish;
      tx_send_q <= tx_send_d;
      tx_data_q <= tx_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign full     = full_w;
  assign empty    = empty_w;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign tx_data  = tx_data_q;
  assign tx_send  = tx_send_q;
  assign busy     = (state_q != ST_IDLE) || !empty_w;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: cycle vectors for the basic
// handshake, plus directed sequences for overflow, reset and a burst.
module tb_uart_tx_feeder;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full, empty, overflow, clr_ovf;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] tx_data;
  logic              tx_send, tx_finish, busy;

  int checks = 0;
  int errors = 0;

  uart_tx_feeder #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .clr_ovf(clr_ovf), .tx_data(tx_data), .tx_send(tx_send),
    .tx_finish(tx_finish), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       clr;
    logic       fin;
    int         cnt;
    logic       send;
    logic [7:0] txd;
    logic       bsy;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_got, peak, timer;
    logic in_flight;
    int exp_cnt3[6] = '{1, 1, 2, 3, 4, 4};

    rst = 1'b1; wr_en = 1'b0; wr_data = '0; clr_ovf = 1'b0; tx_finish = 1'b0;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_txdata", int'(tx_data), 0);
    chk("rst_send", int'(tx_send), 0);
    chk("rst_busy", int'(busy), 0);
    step();
    step();
    rst = 1'b0;

    // Single byte, tx_finish held high in WAIT, and a rise during SEND.
    //                  wr    data   clr   fin   cnt send  txd    busy
    vt.push_back(vec_t'{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b0, 8'h00, 1'b1});
    vt.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 8'hA5, 1'b1});
    vt.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'hA5, 1'b1});
    vt.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'hA5, 1'b1});
    vt.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'hA5, 1'b0});
    vt.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'hA5, 1'b0});
    vt.push_back(vec_t'{1'b1, 8'h11, 1'b0, 1'b1, 1, 1'b0, 8'hA5, 1'b1});
    vt.push_back(vec_t'{1'b1, 8'h22, 1'b0, 1'b1, 1, 1'b1, 8'h11, 1'b1});
    vt.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 8'h11, 1'b1});
    vt.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 8'h11, 1'b1});
    vt.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 8'h11, 1'b1});
    vt.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 8'h11, 1'b1});
    vt.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 8'h11, 1'b1});
    vt.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 8'h22, 1'b1});
    vt.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h22, 1'b1});
    vt.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h22, 1'b1});
    vt.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h22, 1'b0});
    vt.push_back(vec_t'{1'b1, 8'h33, 1'b0, 1'b0, 1, 1'b0, 8'h22, 1'b1});
    vt.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 8'h33, 1'b1});
    vt.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h33, 1'b1});
    vt.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h33, 1'b1});
    vt.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h33, 1'b1});
    vt.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h33, 1'b0});

    foreach (vt[i]) begin
      wr_en = vt[i].wr; wr_data = vt[i].data; clr_ovf = vt[i].clr; tx_finish = vt[i].fin;
      step();
      chk($sformatf("v%0d_count", i), int'(count), vt[i].cnt);
      chk($sformatf("v%0d_send", i), int'(tx_send), int'(vt[i].send));
      chk($sformatf("v%0d_txdata", i), int'(tx_data), int'(vt[i].txd));
      chk($sformatf("v%0d_busy", i), int'(busy), int'(vt[i].bsy));
      chk($sformatf("v%0d_empty", i), int'(empty), int'(vt[i].cnt == 0));
      chk($sformatf("v%0d_full", i), int'(full), int'(vt[i].cnt == DEPTH));
      chk($sformatf("v%0d_ovf", i), int'(overflow), 0);
    end
    wr_en = 1'b0;

    // Fill past DEPTH with tx_finish never rising.
    tx_finish = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      wr_en = 1'b1; wr_data = 8'hB0 + 8'(i);
      step();
      chk($sformatf("fill%0d_count", i), int'(count), exp_cnt3[i]);
      chk($sformatf("fill%0d_ovf", i), int'(overflow), int'(i == DEPTH + 1));
    end
    wr_en = 1'b0;
    chk("fill_full", int'(full), 1);
    chk("fill_txdata", int'(tx_data), 8'hB0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fill_wait_send", int'(tx_send), 0);
    end
    wr_en = 1'b1; clr_ovf = 1'b1; wr_data = 8'hCC;
    step();
    chk("ovf_set_wins", int'(overflow), 1);
    chk("ovf_set_count", int'(count), DEPTH);
    wr_en = 1'b0;
    step();
    chk("ovf_clear", int'(overflow), 0);
    clr_ovf = 1'b0;

    // Pop and dropped write in the same cycle while full.
    tx_finish = 1'b1;
    step();
    chk("pf_idle_count", int'(count), DEPTH);
    chk("pf_idle_send", int'(tx_send), 0);
    wr_en = 1'b1; wr_data = 8'hEE;
    step();
    wr_en = 1'b0;
    chk("pf_count", int'(count), DEPTH - 1);
    chk("pf_ovf", int'(overflow), 1);
    chk("pf_send", int'(tx_send), 1);
    chk("pf_txdata", int'(tx_data), 8'hB1);
    chk("pf_full", int'(full), 0);
    step();
    chk("pf_wait_send", int'(tx_send), 0);
    chk("pf_wait_count", int'(count), 3);

    // Asynchronous reset in WAIT with three bytes queued.
    #2 rst = 1'b1;
    #1;
    chk("arst_send", int'(tx_send), 0);
    chk("arst_count", int'(count), 0);
    chk("arst_empty", int'(empty), 1);
    chk("arst_busy", int'(busy), 0);
    chk("arst_ovf", int'(overflow), 0);
    chk("arst_txdata", int'(tx_data), 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tx_finish = i[0];
      step();
      chk("post_rst_send", int'(tx_send), 0);
      chk("post_rst_busy", int'(busy), 0);
    end

    // Burst of five bytes against a transmitter model.
    tx_finish = 1'b1; in_flight = 1'b0; n_got = 0; peak = 0; timer = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc > 5 && n_got == 5 && !busy) break;
      wr_en = (cyc < 5); wr_data = 8'(cyc + 1);
      step();
      if (int'(count) > peak) peak = int'(count);
      if (tx_send) begin
        chk("burst_after_rise", int'(in_flight), 0);
        chk("burst_txdata", int'(tx_data), n_got + 1);
        n_got++;
        in_flight = 1'b1;
        timer = 0;
      end else if (in_flight) begin
        timer++;
        if (timer == 10)  tx_finish = 1'b0;
        if (timer == 110) begin
          tx_finish = 1'b1;
          in_flight = 1'b0;
        end
      end
    end
    wr_en = 1'b0;
    chk("burst_bytes", n_got, 5);
    chk("burst_peak", peak, 4);
    chk("burst_idle", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
